byte_decode_stream: RTL

- Streaming ByteDecode_d stage, directly upstream of the decompress stage.
- Accepts a packed byte stream of one polynomial: 32*d bytes, LSB-first bit order.
- Emits 256 d-bit coefficients, one per handshake, in index order.
- The coefficient output feeds the decompress stage's x input; for d=12 the output is reduced mod q.

---
 rtl/kyber_pkg.sv | 17 +
 rtl/byte_decode_stream_if.sv | 24 ++
 rtl/bit_unpacker.sv | 37 +++
 rtl/byte_decode_stream.sv | 98 +++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and stage FSM states.
// Imported by the byte-decode stream, its interface and unpacker.
package kyber_pkg;

   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;
   localparam int BUF_W   = 20;

   typedef logic [15:0] coeff_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/byte_decode_stream_if.sv
// Byte-in / coefficient-out handshake bundle of the decode stage.
// slave: the decoder side; master: the feeding/consuming side.
interface byte_decode_stream_if;
   import kyber_pkg::*;

   logic [7:0] in_byte;
   logic       in_valid;
   logic       in_ready;
   coeff_t     coeff;
   logic [7:0] coeff_idx;
   logic       coeff_valid;
   logic       coeff_ready;

   modport master (
      output in_byte, in_valid, coeff_ready,
      input  in_ready, coeff, coeff_idx, coeff_valid
   );

   modport slave (
      input  in_byte, in_valid, coeff_ready,
      output in_ready, coeff, coeff_idx, coeff_valid
   );

endinterface

// File: rtl/bit_unpacker.sv
// LSB-first bit accumulator: appends bytes at cnt, pops d-bit fields.
// Ports: clr/push/pop controls, d width, data byte, cnt and masked bits.
module bit_unpacker
   import kyber_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [3:0]  d,
   input  logic        push,
   input  logic [7:0]  data,
   input  logic        pop,
   output logic [4:0]  cnt,
   output logic [11:0] bits
);

   logic [BUF_W-1:0] acc;
   logic [11:0]      mask;

   // 1<<12 wraps to 0 in 12 bits, so d=12 yields an all-ones mask
   assign mask = (12'd1 << d) - 12'd1;
   assign bits = acc[11:0] & mask;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (push) begin
         acc <= acc | ({{(BUF_W-8){1'b0}}, data} << cnt);
         cnt <= cnt + 5'd8;
      end else if (pop) begin
         acc <= acc >> d;
         cnt <= cnt - {1'b0, d};
      end
   end

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: 32*d packed bytes in, 256 d-bit coeffs out.
// Ports: clk, rst, start, d, stream bus (slave), busy, done, err.
module byte_decode_stream
   import kyber_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           d,
   byte_decode_stream_if.slave  s,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_t      state;
   logic [3:0]  d_lat;
   logic [8:0]  nload;
   logic [4:0]  cnt;
   logic [11:0] bits;
   logic [11:0] red;
   logic        d_ok;
   logic        go;
   logic        all_ld;
   logic        have;
   logic        take;
   logic        load;
   logic        last;

   assign d_ok   = (d != 4'd0) && (d <= 4'd12);
   assign go     = (state == IDLE) && start && d_ok;
   assign busy   = (state == RUN);
   assign all_ld = (nload == 9'(KYBER_N));
   assign have   = (cnt >= {1'b0, d_lat});

   // bytes are only fetched when a full field is not yet buffered,
   // which keeps byte accept and coeff load mutually exclusive
   assign s.in_ready = busy && !have && !all_ld;
   assign take = s.in_valid && s.in_ready;
   assign load = busy && !all_ld && have &&
                 (!s.coeff_valid || s.coeff_ready);
   assign last = busy && s.coeff_valid && s.coeff_ready &&
                 (s.coeff_idx == 8'd255);

   assign red = ((d_lat == 4'd12) && (bits >= 12'(KYBER_Q))) ?
                bits - 12'(KYBER_Q) : bits;

   bit_unpacker u_unpack (
      .clk  (clk),
      .rst  (rst),
      .clr  (go),
      .d    (d_lat),
      .push (take),
      .data (s.in_byte),
      .pop  (load),
      .cnt  (cnt),
      .bits (bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         d_lat         <= '0;
         nload         <= '0;
         s.coeff       <= '0;
         s.coeff_idx   <= '0;
         s.coeff_valid <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= (state == IDLE) && start && !d_ok;
         unique case (state)
            IDLE: if (go) begin
               state       <= RUN;
               d_lat       <= d;
               nload       <= '0;
               s.coeff_idx <= '0;
            end
            RUN: if (last) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (load) begin
            s.coeff       <= {4'b0, red};
            s.coeff_idx   <= nload[7:0];
            s.coeff_valid <= 1'b1;
            nload         <= nload + 9'd1;
         end else if (s.coeff_valid && s.coeff_ready) begin
            s.coeff_valid <= 1'b0;
         end
      end
   end

endmodule
